// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-side PC sequencer: sequencer state encoding,
// default vectors and a small helper for branch-target alignment checks.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0008;
    localparam int          DEF_INC          = 4;
    localparam logic [31:0] PLUS8_STEP       = 32'd8;

    // A branch target is misaligned when either of its two low bits is set.
    function automatic logic target_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state selector for pc_sequencer.
// Applies the per-cycle priority exception > branch > halt > stall > accept.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int              WIDTH      = 32,
    parameter int              INC        = DEF_INC,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  pc_state_t        state,
    input  logic [WIDTH-1:0] pc,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             exc_valid,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             imem_ready,
    output pc_state_t        state_next,
    output logic [WIDTH-1:0] pc_next,
    output logic             fetch_valid,
    output logic             fetch_accept,
    output logic             misaligned_next
);

    // Priority selection of the next PC, next state and the fetch handshake.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        fetch_valid     = 1'b0;
        fetch_accept    = 1'b0;
        misaligned_next = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (exc_valid) begin
                    pc_next = EXC_VECTOR;
                end else if (branch_valid) begin
                    pc_next         = {branch_target[WIDTH-1:2], 2'b00};
                    misaligned_next = target_misaligned(branch_target[1:0]);
                end else if (halt_req) begin
                    state_next = ST_HALTED;
                end else if (stall) begin
                    pc_next = pc;
                end else begin
                    fetch_valid = 1'b1;
                    if (imem_ready) begin
                        fetch_accept = 1'b1;
                        pc_next      = pc + WIDTH'(INC);
                    end else begin
                        pc_next = pc;
                    end
                end
            end
            ST_HALTED: begin
                if (exc_valid) begin
                    pc_next    = EXC_VECTOR;
                    state_next = ST_RUN;
                end else if (resume && !halt_req) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_HALTED;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: BOOT/RUN/HALTED control, branch and
// exception redirect, fetch handshake with instruction memory and a
// saturating accepted-fetch counter.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               INC          = DEF_INC,
    parameter int               CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             exc_valid,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus8,
    output logic             pc_valid,
    output logic             misaligned,
    output logic [CNT_W-1:0] fetch_count,
    output logic             halted
);

    pc_state_t        state_r;
    pc_state_t        state_next_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_next_s;
    logic             fetch_valid_s;
    logic             fetch_accept_s;
    logic             misaligned_next_s;
    logic             misaligned_r;
    logic             halted_r;
    logic [CNT_W-1:0] count_r;

    pc_next_sel #(
        .WIDTH      (WIDTH),
        .INC        (INC),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .state           (state_r),
        .pc              (pc_r),
        .stall           (stall),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .exc_valid       (exc_valid),
        .halt_req        (halt_req),
        .resume          (resume),
        .imem_ready      (imem_ready),
        .state_next      (state_next_s),
        .pc_next         (pc_next_s),
        .fetch_valid     (fetch_valid_s),
        .fetch_accept    (fetch_accept_s),
        .misaligned_next (misaligned_next_s)
    );

    // State, PC and status flag registers; reset abandons anything pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_VECTOR;
            misaligned_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            misaligned_r <= misaligned_next_s;
            halted_r     <= (state_next_s == ST_HALTED);
        end
    end

    // Accepted-fetch counter, sticking at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (fetch_accept_s && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign pc_out      = pc_r;
    assign pc_plus8    = pc_r + WIDTH'(PLUS8_STEP);
    assign pc_valid    = fetch_valid_s;
    assign misaligned  = misaligned_r;
    assign fetch_count = count_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a 32-bit/16-bit-counter instance and an
// 8-bit/2-bit-counter instance share stimulus and are checked against a
// behavioural model of the sequencing rules.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        exc_valid;
    logic        halt_req;
    logic        resume;
    logic        imem_ready;

    logic [31:0] pc_out_a;
    logic [31:0] pc_plus8_a;
    logic        pc_valid_a;
    logic        misaligned_a;
    logic [15:0] fetch_count_a;
    logic        halted_a;

    logic [7:0]  pc_out_b;
    logic [7:0]  pc_plus8_b;
    logic        pc_valid_b;
    logic        misaligned_b;
    logic [1:0]  fetch_count_b;
    logic        halted_b;

    int total = 0;
    int bad   = 0;

    // model state: 0 = boot, 1 = run, 2 = halted; index 0 = wide DUT, 1 = narrow DUT
    int              m_st;
    longint unsigned m_pc  [2];
    longint unsigned m_cnt [2];
    bit              m_mis;
    longint unsigned mask  [2] = '{64'hFFFF_FFFF, 64'hFF};
    longint unsigned cmax  [2] = '{64'd65535, 64'd3};

    always #5 clock = ~clock;

    pc_sequencer u_dut_a (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .exc_valid     (exc_valid),
        .halt_req      (halt_req),
        .resume        (resume),
        .imem_ready    (imem_ready),
        .pc_out        (pc_out_a),
        .pc_plus8      (pc_plus8_a),
        .pc_valid      (pc_valid_a),
        .misaligned    (misaligned_a),
        .fetch_count   (fetch_count_a),
        .halted        (halted_a)
    );

    pc_sequencer #(.WIDTH(8), .CNT_W(2)) u_dut_b (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target[7:0]),
        .exc_valid     (exc_valid),
        .halt_req      (halt_req),
        .resume        (resume),
        .imem_ready    (imem_ready),
        .pc_out        (pc_out_b),
        .pc_plus8      (pc_plus8_b),
        .pc_valid      (pc_valid_b),
        .misaligned    (misaligned_b),
        .fetch_count   (fetch_count_b),
        .halted        (halted_b)
    );

    function automatic bit m_valid();
        return (m_st == 1) && !stall && !exc_valid && !branch_valid && !halt_req;
    endfunction

    task automatic model_step();
        bit v;
        v = m_valid();
        if (reset) begin
            m_st  = 0;
            m_pc  = '{64'd0, 64'd0};
            m_cnt = '{64'd0, 64'd0};
            m_mis = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 1) begin
                if (exc_valid) begin
                    for (int w = 0; w < 2; w++) m_pc[w] = 64'd8;
                end else if (branch_valid) begin
                    for (int w = 0; w < 2; w++)
                        m_pc[w] = longint'(branch_target) & mask[w] & 64'hFFFF_FFFF_FFFF_FFFC;
                    m_mis = (branch_target[1:0] != 2'b00);
                end else if (halt_req) begin
                    m_st = 2;
                end else if (v && imem_ready) begin
                    for (int w = 0; w < 2; w++) begin
                        m_pc[w] = (m_pc[w] + 64'd4) & mask[w];
                        if (m_cnt[w] < cmax[w]) m_cnt[w] = m_cnt[w] + 64'd1;
                    end
                end
            end else begin
                if (exc_valid) begin
                    for (int w = 0; w < 2; w++) m_pc[w] = 64'd8;
                    m_st = 1;
                end else if (resume && !halt_req) begin
                    m_st = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch_valid = 1'b0; branch_target = 32'h0;
        exc_valid = 1'b0; halt_req = 1'b0; resume = 1'b0; imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        #1;
        total++;
        if (pc_out_a !== 32'h0 || pc_out_b !== 8'h0 || pc_valid_a !== 1'b0 || misaligned_a !== 1'b0 ||
            fetch_count_a !== 16'd0 || halted_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: pc=%h pcb=%h valid=%b mis=%b cnt=%0d halted=%b want 0/0/0/0/0/0",
                     pc_out_a, pc_out_b, pc_valid_a, misaligned_a, fetch_count_a, halted_a);
        end
        reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        total++;
        if (pc_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL boot_valid: got %b want 0", pc_valid_a);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            total++;
            if (pc_out_a !== 32'(4 * k) || pc_valid_a !== 1'b1) begin
                bad++;
                $display("FAIL boot_seq%0d: pc=%h valid=%b want %h/1", k, pc_out_a, pc_valid_a, 32'(4 * k));
            end
        end
        tick();
        #1;
        total++;
        if (fetch_count_a !== 16'd3 || fetch_count_b !== 2'd3 || pc_out_a !== 32'hC) begin
            bad++;
            $display("FAIL boot_count: cnt=%0d cntb=%0d pc=%h want 3/3/c", fetch_count_a, fetch_count_b, pc_out_a);
        end
    endtask

    task automatic test_wait_state();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (pc_out_a !== 32'h10 || pc_valid_a !== 1'b1 || fetch_count_a !== 16'd4) begin
                bad++;
                $display("FAIL wait_hold%0d: pc=%h valid=%b cnt=%0d want 10/1/4", k, pc_out_a, pc_valid_a, fetch_count_a);
            end
            if (k < 3) tick();
        end
    endtask

    task automatic test_branch();
        exc_valid = 1'b1; branch_valid = 1'b1; branch_target = 32'h103;
        #1;
        total++;
        if (pc_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL redirect_valid: got %b want 0", pc_valid_a);
        end
        tick();
        exc_valid = 1'b0; branch_valid = 1'b0;
        #1;
        total++;
        if (pc_out_a !== 32'h8 || misaligned_a !== 1'b0) begin
            bad++;
            $display("FAIL exc_over_branch: pc=%h mis=%b want 8/0", pc_out_a, misaligned_a);
        end
        branch_valid = 1'b1;
        tick();
        branch_valid = 1'b0;
        #1;
        total++;
        if (pc_out_a !== 32'h100 || pc_out_b !== 8'h00 || misaligned_a !== 1'b1 || misaligned_b !== 1'b1) begin
            bad++;
            $display("FAIL branch_misaligned: pc=%h pcb=%h mis=%b/%b want 100/00/1/1",
                     pc_out_a, pc_out_b, misaligned_a, misaligned_b);
        end
        tick();
        #1;
        total++;
        if (misaligned_a !== 1'b0) begin
            bad++;
            $display("FAIL misaligned_pulse: got %b want 0", misaligned_a);
        end
    endtask

    task automatic test_wrap();
        branch_valid = 1'b1; branch_target = 32'hFC;
        tick();
        branch_valid = 1'b0; imem_ready = 1'b1;
        #1;
        total++;
        if (pc_out_b !== 8'hFC || pc_plus8_b !== 8'h04 || pc_valid_b !== 1'b1 || pc_plus8_a !== 32'h104) begin
            bad++;
            $display("FAIL wrap_pre: pcb=%h p8b=%h validb=%b p8a=%h want fc/04/1/104",
                     pc_out_b, pc_plus8_b, pc_valid_b, pc_plus8_a);
        end
        tick();
        imem_ready = 1'b0;
        #1;
        total++;
        if (pc_out_b !== 8'h00 || pc_out_a !== 32'h100) begin
            bad++;
            $display("FAIL wrap: pcb=%h pca=%h want 00/100", pc_out_b, pc_out_a);
        end
    endtask

    task automatic test_halt();
        branch_valid = 1'b1; branch_target = 32'h20;
        tick();
        branch_valid = 1'b0; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #1;
        total++;
        if (halted_a !== 1'b1 || pc_valid_a !== 1'b0 || pc_out_a !== 32'h20) begin
            bad++;
            $display("FAIL halt_enter: halted=%b valid=%b pc=%h want 1/0/20", halted_a, pc_valid_a, pc_out_a);
        end
        halt_req = 1'b1; resume = 1'b1;
        tick();
        halt_req = 1'b0;
        #1;
        total++;
        if (halted_a !== 1'b1) begin
            bad++;
            $display("FAIL halt_resume_both: halted=%b want 1", halted_a);
        end
        tick();
        resume = 1'b0;
        #1;
        total++;
        if (halted_a !== 1'b0 || pc_out_a !== 32'h20 || pc_valid_a !== 1'b1) begin
            bad++;
            $display("FAIL resume: halted=%b pc=%h valid=%b want 0/20/1", halted_a, pc_out_a, pc_valid_a);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        #1;
        total++;
        if (pc_out_a !== 32'h8 || halted_a !== 1'b0 || pc_valid_a !== 1'b1) begin
            bad++;
            $display("FAIL exc_wakes_halt: pc=%h halted=%b valid=%b want 8/0/1", pc_out_a, halted_a, pc_valid_a);
        end
    endtask

    task automatic test_saturate_and_reset();
        imem_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        #1;
        total++;
        if (fetch_count_b !== 2'd3 || 64'(fetch_count_a) !== m_cnt[0]) begin
            bad++;
            $display("FAIL saturate: cntb=%0d cnta=%0d want 3/%0d", fetch_count_b, fetch_count_a, m_cnt[0]);
        end
        stall = 1'b1;
        tick();
        reset = 1'b1; branch_valid = 1'b1; branch_target = 32'h44;
        tick();
        reset = 1'b0; stall = 1'b0; branch_valid = 1'b0;
        #1;
        total++;
        if (pc_out_a !== 32'h0 || fetch_count_a !== 16'd0 || fetch_count_b !== 2'd0 || pc_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_stall: pc=%h cnt=%0d cntb=%0d valid=%b want 0/0/0/0",
                     pc_out_a, fetch_count_a, fetch_count_b, pc_valid_a);
        end
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (halted_a !== 1'b0 || pc_out_a !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_halt: halted=%b pc=%h want 0/0", halted_a, pc_out_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 59) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            exc_valid    = ($urandom_range(0, 19) == 0);
            branch_valid = ($urandom_range(0, 9) == 0);
            halt_req     = ($urandom_range(0, 14) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            imem_ready   = ($urandom_range(0, 2) != 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(240, 255)) : $urandom;
            #1;
            total++;
            if (64'(pc_out_a) !== m_pc[0] || 64'(pc_out_b) !== m_pc[1]) begin
                bad++;
                $display("FAIL rnd_pc@%0d: got %h/%h want %h/%h", i, pc_out_a, pc_out_b, m_pc[0], m_pc[1]);
            end
            total++;
            if (64'(pc_plus8_a) !== ((m_pc[0] + 64'd8) & mask[0]) ||
                64'(pc_plus8_b) !== ((m_pc[1] + 64'd8) & mask[1])) begin
                bad++;
                $display("FAIL rnd_plus8@%0d: got %h/%h", i, pc_plus8_a, pc_plus8_b);
            end
            total++;
            if (pc_valid_a !== m_valid() || pc_valid_b !== m_valid()) begin
                bad++;
                $display("FAIL rnd_valid@%0d: got %b/%b want %b", i, pc_valid_a, pc_valid_b, m_valid());
            end
            total++;
            if (misaligned_a !== m_mis || misaligned_b !== m_mis) begin
                bad++;
                $display("FAIL rnd_mis@%0d: got %b/%b want %b", i, misaligned_a, misaligned_b, m_mis);
            end
            total++;
            if (64'(fetch_count_a) !== m_cnt[0] || 64'(fetch_count_b) !== m_cnt[1]) begin
                bad++;
                $display("FAIL rnd_count@%0d: got %0d/%0d want %0d/%0d",
                         i, fetch_count_a, fetch_count_b, m_cnt[0], m_cnt[1]);
            end
            total++;
            if (halted_a !== (m_st == 2) || halted_b !== (m_st == 2)) begin
                bad++;
                $display("FAIL rnd_halted@%0d: got %b/%b want %b", i, halted_a, halted_b, (m_st == 2));
            end
            tick();
        end
    endtask

    initial begin
        m_st  = 0;
        m_pc  = '{64'd0, 64'd0};
        m_cnt = '{64'd0, 64'd0};
        m_mis = 1'b0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_wait_state();
        test_branch();
        test_wrap();
        test_halt();
        test_saturate_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
